// File: rtl/pmcc_tdpram.sv
// pmcc_tdpram: true dual-port byte-enabled RAM with OBI-style req/gnt/rvalid
// handshake on both ports, out-of-range error responses, same-word write
// arbitration (port A wins, port B stalls) and a saturating stall counter.
module pmcc_tdpram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned OUT_REG    = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_a,
    output logic                    gnt_a,
    input  logic [31:0]             addr_a,
    input  logic                    we_a,
    input  logic [DATA_WIDTH/8-1:0] be_a,
    input  logic [DATA_WIDTH-1:0]   wdata_a,
    output logic                    rvalid_a,
    output logic [DATA_WIDTH-1:0]   rdata_a,
    output logic                    err_a,
    input  logic                    req_b,
    output logic                    gnt_b,
    input  logic [31:0]             addr_b,
    input  logic                    we_b,
    input  logic [DATA_WIDTH/8-1:0] be_b,
    input  logic [DATA_WIDTH-1:0]   wdata_b,
    output logic                    rvalid_b,
    output logic [DATA_WIDTH-1:0]   rdata_b,
    output logic                    err_b,
    input  logic                    clr_stats,
    output logic [15:0]             coll_cnt
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned BW    = $clog2(BYTES);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned IW    = BW + AW;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]         idx_a, idx_b;
    logic                  oor_a, oor_b;
    logic                  stall;
    logic                  wr_a, wr_b;
    logic [DATA_WIDTH-1:0] resp_a, resp_b;

    logic                  s1_valid_a, s1_valid_b;
    logic [DATA_WIDTH-1:0] s1_rdata_a, s1_rdata_b;
    logic                  s1_err_a, s1_err_b;

    // Old word with this port's enabled bytes replaced (write-first view)
    function automatic logic [DATA_WIDTH-1:0] merge(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] wd,
        input logic [BYTES-1:0]      be
    );
        logic [DATA_WIDTH-1:0] r;
        r = old_w;
        for (int unsigned i = 0; i < BYTES; i++) begin
            if (be[i]) r[i*8 +: 8] = wd[i*8 +: 8];
        end
        return r;
    endfunction

    // Byte-offset bits only select within a word and are deliberately dropped
    generate
        if (BW > 0) begin : g_unused_low
            logic unused_low;
            assign unused_low = ^{addr_a[BW-1:0], addr_b[BW-1:0]};
        end
    endgenerate

    // Address decode, collision detection and response data selection
    always_comb begin
        idx_a  = addr_a[IW-1:BW];
        idx_b  = addr_b[IW-1:BW];
        oor_a  = |(addr_a >> IW);
        oor_b  = |(addr_b >> IW);
        stall  = req_a && we_a && req_b && we_b && !oor_a && !oor_b &&
                 (idx_a == idx_b) && |(be_a & be_b);
        gnt_a  = req_a;
        gnt_b  = req_b && !stall;
        wr_a   = gnt_a && we_a && !oor_a;
        wr_b   = gnt_b && we_b && !oor_b;
        resp_a = '0;
        resp_b = '0;
        // Reads see the pre-edge word (read-first across ports); own write merged in
        if (!oor_a) resp_a = we_a ? merge(mem[idx_a], wdata_a, be_a) : mem[idx_a];
        if (!oor_b) resp_b = we_b ? merge(mem[idx_b], wdata_b, be_b) : mem[idx_b];
    end

    // Memory array update; overlapping same-word writes never reach here
    // because port B is stalled, so disjoint byte writes can merge freely
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (wr_a && be_a[b]) mem[idx_a][b*8 +: 8] <= wdata_a[b*8 +: 8];
                if (wr_b && be_b[b]) mem[idx_b][b*8 +: 8] <= wdata_b[b*8 +: 8];
            end
        end
    end

    // First response stage: one pulse per grant, data held between responses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_a <= 1'b0;
            s1_rdata_a <= '0;
            s1_err_a   <= 1'b0;
            s1_valid_b <= 1'b0;
            s1_rdata_b <= '0;
            s1_err_b   <= 1'b0;
        end else begin
            s1_valid_a <= gnt_a;
            s1_valid_b <= gnt_b;
            if (gnt_a) begin
                s1_rdata_a <= resp_a;
                s1_err_a   <= oor_a;
            end
            if (gnt_b) begin
                s1_rdata_b <= resp_b;
                s1_err_b   <= oor_b;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            // Optional output stage; holds its data while no response arrives
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rvalid_a <= 1'b0;
                    rdata_a  <= '0;
                    err_a    <= 1'b0;
                    rvalid_b <= 1'b0;
                    rdata_b  <= '0;
                    err_b    <= 1'b0;
                end else begin
                    rvalid_a <= s1_valid_a;
                    rvalid_b <= s1_valid_b;
                    if (s1_valid_a) begin
                        rdata_a <= s1_rdata_a;
                        err_a   <= s1_err_a;
                    end
                    if (s1_valid_b) begin
                        rdata_b <= s1_rdata_b;
                        err_b   <= s1_err_b;
                    end
                end
            end
        end else begin : g_no_out_reg
            // Single-cycle latency: expose the first stage directly
            always_comb begin
                rvalid_a = s1_valid_a;
                rdata_a  = s1_rdata_a;
                err_a    = s1_err_a;
                rvalid_b = s1_valid_b;
                rdata_b  = s1_rdata_b;
                err_b    = s1_err_b;
            end
        end
    endgenerate

    // Saturating stall counter; clear takes priority over a concurrent stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_cnt <= '0;
        end else if (clr_stats) begin
            coll_cnt <= '0;
        end else if (stall && (coll_cnt != '1)) begin
            coll_cnt <= coll_cnt + 16'd1;
        end
    end

endmodule

// File: doc/pmcc_tdpram.md
# pmcc_tdpram

Parametrised true dual-port byte-enabled RAM for the PMC controller, successor to the single-write-port program/data RAM. Both ports read and write, use an OBI-style req/gnt/rvalid handshake, and support configurable data width, depth and an optional output register stage. The block adds out-of-range error responses, deterministic same-word write arbitration with a port B stall, and a saturating collision counter for debug.

## Interface
- DATA_WIDTH, 32: word width in bits; multiple of 8, between 8 and 128. BYTES = DATA_WIDTH/8.
- DEPTH, 256: number of words; power of two, at least 2.
- OUT_REG, 0: 0 gives 1-cycle read latency; 1 adds an output register (2-cycle latency).
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_a / req_b  in  1  access request.
- gnt_a / gnt_b  out  1  request accepted this cycle (combinational).
- addr_a / addr_b  in  32  byte address.
- we_a / we_b  in  1  1 = write, 0 = read.
- be_a / be_b  in  BYTES  byte enables for writes; ignored for reads.
- wdata_a / wdata_b  in  DATA_WIDTH  write data.
- rvalid_a / rvalid_b  out  1  response valid, one pulse per granted request.
- rdata_a / rdata_b  out  DATA_WIDTH  response data.
- err_a / err_b  out  1  response error; qualified by rvalid.
- clr_stats  in  1  synchronous clear of coll_cnt.
- coll_cnt  out  16  saturating count of port B stall cycles.

## Operation
- Word index = addr[log2(BYTES)+log2(DEPTH)-1 : log2(BYTES)]. Low log2(BYTES) bits are ignored, so misaligned addresses are forced to word alignment.
- Out of range: address bits at or above log2(BYTES*DEPTH) are nonzero.
  - The request is granted, has no memory effect, and returns rdata = 0 with err = 1.
- gnt_a = req_a, always.
- gnt_b = req_b, except it is 0 when all of the following hold in the same cycle:
  - req_a and we_a are 1, and req_b and we_b are 1;
  - both addresses are in range and index the same word;
  - (be_a & be_b) != 0.
- While stalled, port B must hold req/addr/we/be/wdata stable until granted. Port B is granted the cycle after port A stops colliding.
- Same-word writes with disjoint byte enables are both granted and both bytes sets are written in that cycle.
- Read-during-write ordering:
  - Same port: write-first. A granted write returns the post-write word in rdata with err = 0.
  - Cross port: read-first. A port reading a word the other port writes in the same cycle returns the old contents.
- coll_cnt increments by 1 on every stall cycle and saturates at 16'hFFFF.
  - clr_stats sets it to 0; if a stall occurs in the same cycle, clr_stats wins.
- Memory contents are not reset and are X until written.

## Timing
- Reset values: rvalid_a/b = 0, rdata_a/b = 0, err_a/b = 0, coll_cnt = 0. gnt follows req combinationally, including during reset.
- Requests presented while rst_n = 0 are discarded and produce no rvalid. Any in-flight response (OUT_REG = 1 pipeline) is flushed by reset.
- OUT_REG = 0: a request granted in cycle N gives rvalid, rdata and err in cycle N+1.
- OUT_REG = 1: the response appears in cycle N+2.
- Back-to-back granted requests give back-to-back rvalid pulses, one per grant, in order.
- rdata/err hold their last response value while rvalid = 0.
- A stall cycle produces no rvalid on port B.
- Both ports are fully independent apart from the collision rule. Each can complete one access per cycle.

## Test plan
- Write A addr 0x10, be 4'hF, data 0xDEADBEEF; then read B addr 0x10 -> B rvalid one cycle after grant, rdata 0xDEADBEEF, err 0. With OUT_REG = 1, rvalid is two cycles after grant.
- Same-word collision: A writes 0x11111111 (be 4'hF) and B writes 0x22222222 (be 4'h1) to addr 0x20 in the same cycle -> gnt_b = 0 for 1 cycle, coll_cnt = 1. B is granted the next cycle; a later read of 0x20 returns 0x11111122.
- Disjoint bytes: A be 4'hC data 0xAABB0000, B be 4'h3 data 0x0000CCDD, both to 0x30 -> both granted, coll_cnt unchanged, a read returns 0xAABBCCDD.
- Cross-port read-first: 0x40 holds 0x1; A writes 0x2 while B reads 0x40 in the same cycle -> B rdata 0x1, A rdata 0x2.
- Out of range with DEPTH = 256 (1 KiB): A write to 0x400 -> rvalid with err = 1, rdata 0, and the word at 0x0 is unchanged. A misaligned read at 0x13 returns the word at 0x10.
- Saturation and reset: force 70000 stall cycles -> coll_cnt = 0xFFFF; assert clr_stats -> 0. Assert rst_n low while a read is in flight (OUT_REG = 1) -> no rvalid appears and all outputs are 0.
